// File: rtl/cache_control_nway.sv
// N-way cache controller: hits answer in the request cycle; misses write back a dirty victim, fill, then retry.
// Optional CACHE_CTRL_PERF_EN adds saturating hit/miss/write-back counters; the request is held without mem_resp while pmem is busy.
module cache_control_nway #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4,
    localparam int S_TAG   = 32 - S_OFFSET - S_INDEX,
    localparam int WB      = $clog2(NUM_WAYS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               address,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [NUM_WAYS-1:0]       hit_way,
    input  logic [NUM_WAYS-1:0]       valid_way,
    input  logic [NUM_WAYS-1:0]       dirty_way,
    input  logic [NUM_WAYS*S_TAG-1:0] tag_flat,
    input  logic [WB-1:0]             lru_way,
    input  logic                      pmem_resp,
    output logic [WB-1:0]             way_sel,
    output logic                      data_write,
    output logic                      fill_load,
    output logic                      tag_load,
    output logic                      dirty_load,
    output logic                      dirty_in,
    output logic                      lru_load,
    output logic                      pmem_read,
    output logic                      pmem_write,
    output logic [31:0]               pmem_address,
    output logic                      mem_resp,
    output logic [31:0]               perf_hit_count,
    output logic [31:0]               perf_miss_count,
    output logic [31:0]               perf_wb_count
);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WB-1:0]    r_victim;
    logic [S_TAG-1:0] r_victim_tag;

    logic             w_mem_op;
    logic             w_hit;
    logic [WB-1:0]    w_hit_idx;
    logic [WB-1:0]    w_victim;
    logic             w_has_invalid;
    logic             w_victim_dirty;
    logic [S_TAG-1:0] w_victim_tag;
    logic             w_unused;

    assign w_mem_op       = mem_read | mem_write;
    assign w_hit          = |hit_way;
    assign w_victim_dirty = valid_way[w_victim] & dirty_way[w_victim];
    assign w_victim_tag   = tag_flat[int'(w_victim)*S_TAG +: S_TAG];
    assign w_unused       = ^address[S_OFFSET-1:0];

    // Descending scans leave the lowest-index match in the result.
    always_comb begin
        w_hit_idx     = '0;
        w_victim      = lru_way;
        w_has_invalid = 1'b0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit_way[i]) begin
                w_hit_idx = WB'(i);
            end
            if (!valid_way[i]) begin
                w_victim      = WB'(i);
                w_has_invalid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_victim     <= '0;
            r_victim_tag <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_mem_op && !w_hit) begin
                r_victim     <= w_victim;
                r_victim_tag <= w_victim_tag;
            end
        end
    end

    // Outputs are gated by rst_n so an asserted reset silences them without a clock edge.
    always_comb begin
        w_next       = r_state;
        way_sel      = '0;
        data_write   = 1'b0;
        fill_load    = 1'b0;
        tag_load     = 1'b0;
        dirty_load   = 1'b0;
        dirty_in     = 1'b0;
        lru_load     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        mem_resp     = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op && w_hit) begin
                        mem_resp   = 1'b1;
                        way_sel    = w_hit_idx;
                        lru_load   = 1'b1;
                        data_write = mem_write;
                        dirty_load = mem_write;
                        dirty_in   = mem_write;
                    end else if (w_mem_op) begin
                        w_next = (w_victim_dirty && !w_has_invalid) ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    pmem_write   = 1'b1;
                    pmem_address = {r_victim_tag, address[S_OFFSET +: S_INDEX], {S_OFFSET{1'b0}}};
                    way_sel      = r_victim;
                    if (pmem_resp) begin
                        dirty_load = 1'b1;
                        w_next     = S_FILL;
                    end
                end
                S_FILL: begin
                    pmem_read    = 1'b1;
                    pmem_address = {address[31:S_OFFSET], {S_OFFSET{1'b0}}};
                    way_sel      = r_victim;
                    if (pmem_resp) begin
                        fill_load = 1'b1;
                        tag_load  = 1'b1;
                        w_next    = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    logic [31:0] r_perf_hit;
    logic [31:0] r_perf_miss;
    logic [31:0] r_perf_wb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
            r_perf_wb   <= '0;
        end else begin
            if (mem_resp && r_perf_hit != '1) begin
                r_perf_hit <= r_perf_hit + 32'd1;
            end
            if (fill_load && r_perf_miss != '1) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end
            if (r_state == S_WB && pmem_resp && r_perf_wb != '1) begin
                r_perf_wb <= r_perf_wb + 32'd1;
            end
        end
    end

    assign perf_hit_count  = r_perf_hit;
    assign perf_miss_count = r_perf_miss;
    assign perf_wb_count   = r_perf_wb;
`else
    assign perf_hit_count  = '0;
    assign perf_miss_count = '0;
    assign perf_wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control_nway.sv
// Bench for cache_control_nway: a set/way array model feeds the datapath inputs and a pmem-operation queue predicts every output.
module tb_cache_control_nway;

    localparam int NS = 8;
    localparam int NW = 4;
    localparam int ST = 24;
    localparam int A_NONE = 0, A_HIT = 1, A_MISS = 2, A_RESP = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       address = '0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic [NW-1:0]     hit_way = '0;
    logic [NW-1:0]     valid_way = '0;
    logic [NW-1:0]     dirty_way = '0;
    logic [NW*ST-1:0]  tag_flat = '0;
    logic [1:0]        lru_way = '0;
    logic              pmem_resp = 1'b0;
    logic [1:0]        way_sel;
    logic              data_write, fill_load, tag_load, dirty_load, dirty_in, lru_load;
    logic              pmem_read, pmem_write, mem_resp;
    logic [31:0]       pmem_address, perf_hit_count, perf_miss_count, perf_wb_count;

    cache_control_nway #(.S_OFFSET(5), .S_INDEX(3), .NUM_WAYS(4)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .mem_read(mem_read), .mem_write(mem_write),
        .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way), .tag_flat(tag_flat),
        .lru_way(lru_way), .pmem_resp(pmem_resp), .way_sel(way_sel), .data_write(data_write),
        .fill_load(fill_load), .tag_load(tag_load), .dirty_load(dirty_load), .dirty_in(dirty_in),
        .lru_load(lru_load), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .mem_resp(mem_resp), .perf_hit_count(perf_hit_count),
        .perf_miss_count(perf_miss_count), .perf_wb_count(perf_wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          way;
    } op_t;

    logic [ST-1:0] tag_a [NS][NW];
    bit            val_a [NS][NW];
    bit            dty_a [NS][NW];
    int            stamp [NS][NW];
    int            now = 100;
    op_t           pend_q[$];
    int            wait_cnt = 0;
    int            lat_force = -1;
    int            act = A_NONE;
    int            act_way = 0;
    bit            done = 0;
    int            cnt_hit = 0, cnt_fill = 0, cnt_wb = 0;
    int            checks = 0, failures = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
        end
    endtask

    function automatic int lru_of(input int s);
        int b = 0;
        for (int w = 1; w < NW; w++) if (stamp[s][w] < stamp[s][b]) b = w;
        return b;
    endfunction

    function automatic int victim_of(input int s);
        for (int w = 0; w < NW; w++) if (!val_a[s][w]) return w;
        return lru_of(s);
    endfunction

    function automatic logic [31:0] mk(input logic [ST-1:0] t, input int s, input int off);
        return {t, 3'(s), 5'(off)};
    endfunction

    function automatic int lat();
        return (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
    endfunction

    task automatic set_way(input int s, input int w, input logic [ST-1:0] t, input bit v, input bit d, input int st);
        tag_a[s][w] = t; val_a[s][w] = v; dty_a[s][w] = d; stamp[s][w] = st;
    endtask

    task automatic drive_dp();
        int s = int'(address[7:5]);
        for (int w = 0; w < NW; w++) begin
            hit_way[w]             = val_a[s][w] && (tag_a[s][w] == address[31:8]);
            valid_way[w]           = val_a[s][w];
            dirty_way[w]           = dty_a[s][w];
            tag_flat[w*ST +: ST]   = tag_a[s][w];
        end
        lru_way = 2'(lru_of(s));
    endtask

    // First half of a cycle: drive inputs, then predict and compare all outputs at the falling edge.
    task automatic mid();
        logic [31:0] e_addr = '0;
        logic [1:0]  e_way = '0;
        bit e_resp = 0, e_dw = 0, e_fl = 0, e_tl = 0, e_dl = 0, e_di = 0, e_lru = 0, e_pr = 0, e_pw = 0;
        int s, hw;
        pmem_resp = 1'b0;
        if (pend_q.size() > 0) begin
            if (wait_cnt == 0) pmem_resp = 1'b1;
            else wait_cnt--;
        end
        drive_dp();
        #4;
        act = A_NONE;
        s = int'(address[7:5]);
        if (pend_q.size() == 0) begin
            if (mem_read || mem_write) begin
                hw = -1;
                for (int w = NW - 1; w >= 0; w--)
                    if (val_a[s][w] && tag_a[s][w] == address[31:8]) hw = w;
                if (hw >= 0) begin
                    act = A_HIT; act_way = hw;
                    e_resp = 1; e_way = 2'(hw); e_lru = 1;
                    e_dw = mem_write; e_dl = mem_write; e_di = mem_write;
                end else begin
                    act = A_MISS;
                end
            end
        end else begin
            e_pw = pend_q[0].wr; e_pr = !pend_q[0].wr;
            e_addr = pend_q[0].addr; e_way = 2'(pend_q[0].way);
            if (pmem_resp) begin
                act = A_RESP;
                if (pend_q[0].wr) e_dl = 1;
                else begin e_fl = 1; e_tl = 1; end
            end
        end
        chk("mem_resp", 32'(mem_resp), 32'(e_resp));
        chk("way_sel", 32'(way_sel), 32'(e_way));
        chk("lru_load", 32'(lru_load), 32'(e_lru));
        chk("data_write", 32'(data_write), 32'(e_dw));
        chk("dirty_load", 32'(dirty_load), 32'(e_dl));
        chk("dirty_in", 32'(dirty_in), 32'(e_di));
        chk("fill_load", 32'(fill_load), 32'(e_fl));
        chk("tag_load", 32'(tag_load), 32'(e_tl));
        chk("pmem_read", 32'(pmem_read), 32'(e_pr));
        chk("pmem_write", 32'(pmem_write), 32'(e_pw));
        chk("pmem_address", pmem_address, e_addr);
`ifdef CACHE_CTRL_PERF_EN
        chk("perf_hit", perf_hit_count, 32'(cnt_hit));
        chk("perf_miss", perf_miss_count, 32'(cnt_fill));
        chk("perf_wb", perf_wb_count, 32'(cnt_wb));
`else
        chk("perf_hit", perf_hit_count, 32'd0);
        chk("perf_miss", perf_miss_count, 32'd0);
        chk("perf_wb", perf_wb_count, 32'd0);
`endif
    endtask

    // Second half: cross the rising edge, then apply the predicted effects to the array model.
    task automatic fin();
        int s, v;
        op_t o;
        @(posedge clk);
        #1;
        s = int'(address[7:5]);
        case (act)
            A_HIT: begin
                now++;
                stamp[s][act_way] = now;
                if (mem_write) dty_a[s][act_way] = 1;
                cnt_hit++;
                mem_read = 1'b0; mem_write = 1'b0; done = 1;
            end
            A_MISS: begin
                v = victim_of(s);
                if (val_a[s][v] && dty_a[s][v])
                    pend_q.push_back('{wr: 1'b1, addr: {tag_a[s][v], 3'(s), 5'b0}, way: v});
                pend_q.push_back('{wr: 1'b0, addr: {address[31:5], 5'b0}, way: v});
                wait_cnt = lat();
            end
            A_RESP: begin
                o = pend_q.pop_front();
                if (o.wr) begin
                    dty_a[s][o.way] = 0; cnt_wb++;
                end else begin
                    tag_a[s][o.way] = address[31:8]; val_a[s][o.way] = 1; cnt_fill++;
                end
                wait_cnt = lat();
            end
            default: ;
        endcase
        act = A_NONE;
    endtask

    task automatic run_txn(input logic [31:0] a, input bit wr, input bit wd);
        bit ended = 0;
        bit withdrawn = 0;
        address = a; mem_read = !wr; mem_write = wr; done = 0;
        for (int n = 0; n < 200 && !ended; n++) begin
            mid();
            fin();
            if (done) ended = 1;
            else if (withdrawn && pend_q.size() == 0) ended = 1;
            else if (wd && !withdrawn && pend_q.size() > 0) begin
                mem_read = 1'b0; mem_write = 1'b0; withdrawn = 1;
            end
        end
        if (!ended) chk("txn_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_resp_cycle(input string n);
        bit seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            mid();
            if (pmem_resp) begin
                seen = 1;
                if (pend_q[0].wr) begin
                    chk({n, "_dirty_load"}, 32'(dirty_load), 32'd1);
                    chk({n, "_dirty_in"}, 32'(dirty_in), 32'd0);
                end else begin
                    chk({n, "_fill_load"}, 32'(fill_load), 32'd1);
                    chk({n, "_tag_load"}, 32'(tag_load), 32'd1);
                end
            end
            fin();
        end
        if (!seen) chk({n, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) set_way(s, w, '0, 0, 0, 0);

        // Reset held with a hitting request: outputs must stay quiet.
        #1;
        hit_way = 4'b0001; mem_read = 1'b1;
        #1;
        chk("rst_mem_resp", 32'(mem_resp), 32'd0);
        chk("rst_way_sel", 32'(way_sel), 32'd0);
        chk("rst_lru_load", 32'(lru_load), 32'd0);
        chk("rst_perf_hit", perf_hit_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; mem_read = 1'b0;

        // Read hit on way 2, write hit on way 0.
        set_way(0, 0, 24'h000002, 1, 0, 1);
        set_way(0, 2, 24'h000001, 1, 0, 2);
        address = 32'h0000_0100; mem_read = 1'b1; done = 0;
        mid();
        chk("h35_mem_resp", 32'(mem_resp), 32'd1);
        chk("h35_way_sel", 32'(way_sel), 32'd2);
        chk("h35_lru_load", 32'(lru_load), 32'd1);
        chk("h35_pmem_read", 32'(pmem_read), 32'd0);
        fin();
        address = 32'h0000_0200; mem_write = 1'b1; done = 0;
        mid();
        chk("h36_mem_resp", 32'(mem_resp), 32'd1);
        chk("h36_data_write", 32'(data_write), 32'd1);
        chk("h36_dirty_load", 32'(dirty_load), 32'd1);
        chk("h36_dirty_in", 32'(dirty_in), 32'd1);
        chk("h36_way_sel", 32'(way_sel), 32'd0);
        fin();

        // Clean miss into the invalid way 2 of set 2.
        set_way(2, 0, 24'h000111, 1, 0, 5);
        set_way(2, 1, 24'h000222, 1, 0, 6);
        set_way(2, 2, 24'h000000, 0, 0, 0);
        set_way(2, 3, 24'h000333, 1, 0, 7);
        lat_force = 2;
        address = 32'h8000_0044; mem_read = 1'b1; done = 0;
        mid();
        chk("m37_detect_resp", 32'(mem_resp), 32'd0);
        fin();
        mid();
        chk("m37_way_sel", 32'(way_sel), 32'd2);
        chk("m37_pmem_read", 32'(pmem_read), 32'd1);
        chk("m37_pmem_addr", pmem_address, 32'h8000_0040);
        fin();
        wait_resp_cycle("m37");
        mid();
        chk("m37_retry_resp", 32'(mem_resp), 32'd1);
        chk("m37_retry_way", 32'(way_sel), 32'd2);
        fin();

        // Dirty LRU victim way 1 with stored tag 0x123456.
        set_way(2, 0, 24'h000111, 1, 0, 10);
        set_way(2, 1, 24'h123456, 1, 1, 1);
        set_way(2, 2, 24'h000222, 1, 0, 11);
        set_way(2, 3, 24'h000333, 1, 0, 12);
        address = 32'h8000_0040; mem_read = 1'b1; done = 0;
        mid();
        fin();
        mid();
        chk("m38_pmem_write", 32'(pmem_write), 32'd1);
        chk("m38_pmem_addr", pmem_address, 32'h1234_5640);
        chk("m38_way_sel", 32'(way_sel), 32'd1);
        fin();
        wait_resp_cycle("m38_wb");
        mid();
        chk("m38_fill_read", 32'(pmem_read), 32'd1);
        chk("m38_fill_write", 32'(pmem_write), 32'd0);
        chk("m38_fill_addr", pmem_address, 32'h8000_0040);
        fin();
        run_txn(32'h8000_0040, 0, 0);
        chk("m38_done", 32'(done), 32'd1);

        // Asynchronous reset in the middle of a fill.
        for (int w = 0; w < NW; w++) set_way(3, w, 24'(32'h40 + w), 1, 0, 20 + w);
        lat_force = 5;
        address = mk(24'h55, 3, 4); mem_read = 1'b1; done = 0;
        mid();
        fin();
        mid();
        chk("r39_fill_before", 32'(pmem_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r39_pmem_read", 32'(pmem_read), 32'd0);
        chk("r39_pmem_addr", pmem_address, 32'd0);
        chk("r39_way_sel", 32'(way_sel), 32'd0);
        mem_read = 1'b0; pend_q.delete(); act = A_NONE; wait_cnt = 0;
        cnt_hit = 0; cnt_fill = 0; cnt_wb = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat_force = -1;

        // Three hits plus one dirty miss after reset.
        set_way(5, 0, 24'h10, 1, 1, 1);
        set_way(5, 1, 24'h11, 1, 0, 2);
        set_way(5, 2, 24'h12, 1, 0, 3);
        set_way(5, 3, 24'h13, 1, 0, 4);
        run_txn(mk(24'h11, 5, 0), 0, 0);
        run_txn(mk(24'h12, 5, 8), 0, 0);
        run_txn(mk(24'h13, 5, 16), 0, 0);
        run_txn(mk(24'h20, 5, 0), 0, 0);
        chk("p40_done", 32'(done), 32'd1);
`ifdef CACHE_CTRL_PERF_EN
        chk("p40_hits", perf_hit_count, 32'd4);
        chk("p40_miss", perf_miss_count, 32'd1);
        chk("p40_wb", perf_wb_count, 32'd1);
`else
        chk("p40_hits", perf_hit_count, 32'd0);
        chk("p40_miss", perf_miss_count, 32'd0);
        chk("p40_wb", perf_wb_count, 32'd0);
`endif

        // Random mix over a small tag pool, with occasional withdrawn requests.
        for (int i = 0; i < 300; i++) begin
            run_txn(mk(24'($urandom_range(0, 5)), int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 31))),
                    bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end
        mid();
        fin();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
